scanline_sched_analogizer: RTL and testbench

//  Per-line scheduler for the Analogizer scanline dimmer. Holds the host scanline config, applies it

---
 rtl/scanline_sched_analogizer.sv | 94 +++++++++
 tb/tb_scanline_sched_analogizer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_sched_analogizer.sv
// scanline_sched_analogizer: per-line dim-level scheduler with frame-boundary config apply and line-count stability.
// Define SCANLINE_PHASE_ALT_EN to start the pattern at phase 1 on odd frames (interlace-style alternation).
module scanline_sched_analogizer #(
  parameter int LINE_W        = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_mode,
  input  logic [2:0]        cfg_period,
  input  logic [7:0]        cfg_mask,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  output logic [1:0]        level_out,
  output logic              cfg_pending,
  output logic [LINE_W-1:0] frame_lines,
  output logic              stable
);
  localparam logic [3:0] MATCH_MAX = 4'(STABLE_FRAMES - 1);
  logic              hs_q, vs_q, de_seen, vf, hf, same_cnt;
  logic [1:0]        pend_mode, act_mode, nxt_mode;
  logic [2:0]        pend_period, act_period, nxt_period, phase, phase_start;
  logic [7:0]        pend_mask, act_mask, nxt_mask;
  logic [LINE_W-1:0] line_cnt;
  logic [3:0]        match_cnt;
  always_comb begin
    vf         = vs_q & ~vs_in;
    hf         = hs_q & ~hs_in & ~vf;
    same_cnt   = (line_cnt == frame_lines) && (line_cnt != '0);
    nxt_mode   = (vf & cfg_wr) ? cfg_mode   : (vf & cfg_pending) ? pend_mode   : act_mode;
    nxt_period = (vf & cfg_wr) ? cfg_period : (vf & cfg_pending) ? pend_period : act_period;
    nxt_mask   = (vf & cfg_wr) ? cfg_mask   : (vf & cfg_pending) ? pend_mask   : act_mask;
  end
`ifdef SCANLINE_PHASE_ALT_EN
  logic parity;
  // parity is about to toggle, so the frame being started is odd when parity is currently 0
  assign phase_start = (!parity && nxt_period != 3'd0) ? 3'd1 : 3'd0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) parity <= 1'b0;
    else if (vf)  parity <= ~parity;
`else
  assign phase_start = 3'd0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      level_out   <= 2'd0;
      cfg_pending <= 1'b0;
      pend_mode   <= 2'd0;
      pend_period <= 3'd0;
      pend_mask   <= 8'd0;
      act_mode    <= 2'd0;
      act_period  <= 3'd0;
      act_mask    <= 8'd0;
      phase       <= 3'd0;
      line_cnt    <= '0;
      frame_lines <= '0;
      de_seen     <= 1'b0;
      match_cnt   <= 4'd0;
    end else begin
      hs_q        <= hs_in;
      vs_q        <= vs_in;
      level_out   <= act_mask[phase] ? act_mode : 2'd0;
      cfg_pending <= vf ? 1'b0 : (cfg_wr | cfg_pending);
      act_mode    <= nxt_mode;
      act_period  <= nxt_period;
      act_mask    <= nxt_mask;
      if (cfg_wr) begin
        pend_mode   <= cfg_mode;
        pend_period <= cfg_period;
        pend_mask   <= cfg_mask;
      end
      if (vf) begin
        phase       <= phase_start;
        frame_lines <= line_cnt;
        line_cnt    <= '0;
        de_seen     <= 1'b0;
        match_cnt   <= !same_cnt ? 4'd0 : (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + 4'd1;
      end else if (hf) begin
        if (de_seen | de_in) begin
          line_cnt <= (line_cnt == '1) ? line_cnt : line_cnt + LINE_W'(1);
          phase    <= (phase >= act_period) ? 3'd0 : phase + 3'd1;
        end
        de_seen <= 1'b0;
      end else begin
        de_seen <= de_seen | de_in;
      end
    end
  end
  assign stable = (match_cnt == MATCH_MAX);
endmodule

// File: tb/tb_scanline_sched_analogizer.sv
// tb_scanline_sched_analogizer: randomized line/frame stimulus checked against a frame-level reference model.
// Two instances (LINE_W 12 and 8) share stimulus so counter saturation is observable.
module tb_scanline_sched_analogizer;
  localparam int S = 2;
  logic clk = 1'b0, reset_n = 1'b0, cfg_wr = 1'b0, hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [2:0] cfg_period = 3'd0;
  logic [7:0] cfg_mask = 8'd0;
  logic [1:0] lvl_a, lvl_b;
  logic pend_a, pend_b, stb_a, stb_b;
  logic [11:0] fl_a;
  logic [7:0] fl_b;
  int tests = 0, fails = 0;
  logic [1:0] m_mode, p_mode;
  logic [2:0] m_per, p_per;
  logic [7:0] m_mask, p_mask;
  bit m_pend;
  int m_cnt, m_phase;
  int hist12[$], hist8[$];

  scanline_sched_analogizer #(.LINE_W(12), .STABLE_FRAMES(S)) dut_a (
    .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_mask(cfg_mask), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .level_out(lvl_a),
    .cfg_pending(pend_a), .frame_lines(fl_a), .stable(stb_a));
  scanline_sched_analogizer #(.LINE_W(8), .STABLE_FRAMES(S)) dut_b (
    .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_mask(cfg_mask), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .level_out(lvl_b),
    .cfg_pending(pend_b), .frame_lines(fl_b), .stable(stb_b));

  always #5 clk = ~clk;

  // stable is true once the last S reported frame counts are identical and nonzero
  function automatic bit stable_of(input int h[$]);
    if (h.size() < S) return 1'b0;
    for (int i = 1; i <= S; i++)
      if (h[h.size()-i] != h[h.size()-1] || h[h.size()-1] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int last_of(input int h[$]);
    return (h.size() == 0) ? 0 : h[h.size()-1];
  endfunction

  function automatic logic [1:0] exp_level();
    return m_mask[m_phase] ? m_mode : 2'd0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_per = 0; m_mask = 0; p_mode = 0; p_per = 0; p_mask = 0;
    m_pend = 0; m_cnt = 0; m_phase = 0;
    hist12.delete(); hist8.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_line(input bit act);
    int n = $urandom_range(2, 5);
    int pos = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      de_in = act && (i == pos || $urandom_range(0, 1) == 1);
      tick();
    end
    de_in = 1'b0; hs_in = 1'b1; tick(); tick();
    hs_in = 1'b0; tick(); tick();
    if (act) begin
      m_cnt++;
      m_phase = (m_phase >= int'(m_per)) ? 0 : m_phase + 1;
    end
  endtask

  task automatic drive_vsync(input bit wr, input logic [1:0] md, input logic [2:0] per, input logic [7:0] mk);
    vs_in = 1'b1; tick(); tick();
    vs_in = 1'b0;
    if (wr) begin cfg_mode = md; cfg_period = per; cfg_mask = mk; cfg_wr = 1'b1; end
    tick(); cfg_wr = 1'b0; tick();
    if (wr) begin m_mode = md; m_per = per; m_mask = mk; m_pend = 0; end
    else if (m_pend) begin m_mode = p_mode; m_per = p_per; m_mask = p_mask; m_pend = 0; end
    hist12.push_back(m_cnt > 4095 ? 4095 : m_cnt);
    hist8.push_back(m_cnt > 255 ? 255 : m_cnt);
    m_cnt = 0; m_phase = 0;
  endtask

  task automatic cfg_write(input logic [1:0] md, input logic [2:0] per, input logic [7:0] mk);
    cfg_mode = md; cfg_period = per; cfg_mask = mk; cfg_wr = 1'b1;
    tick(); cfg_wr = 1'b0; tick();
    p_mode = md; p_per = per; p_mask = mk; m_pend = 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; model_reset();
    tick(); tick();
    tests++;
    if ({lvl_a, lvl_b, pend_a, pend_b, fl_a, fl_b, stb_a, stb_b} !== '0) begin
      fails++; $display("FAIL reset: lvl=%0d/%0d pend=%b/%b fl=%0d/%0d stable=%b/%b, want all 0",
                        lvl_a, lvl_b, pend_a, pend_b, fl_a, fl_b, stb_a, stb_b);
    end
    reset_n = 1'b1; tick();
  endtask

  task automatic test_idle_frames();
    drive_vsync(0, 0, 0, 0);
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 240; l++) begin
        drive_line(1);
        tests++;
        if (lvl_a !== 2'd0 || lvl_b !== 2'd0) begin
          fails++; $display("FAIL idle_level f%0d l%0d: got %0d/%0d want 0", f, l, lvl_a, lvl_b);
        end
      end
      drive_vsync(0, 0, 0, 0);
      tests++;
      if (fl_a !== 12'd240 || fl_b !== 8'd240 || stb_a !== (f == 1) || stb_b !== (f == 1)) begin
        fails++; $display("FAIL idle_frame f%0d: fl=%0d/%0d stable=%b/%b want 240 stable=%0d",
                          f, fl_a, fl_b, stb_a, stb_b, f == 1);
      end
    end
  endtask

  task automatic test_cfg_midframe();
    for (int l = 0; l < 4; l++) drive_line(1);
    cfg_write(2'd2, 3'd1, 8'b10);
    tests++;
    if (pend_a !== 1'b1 || pend_b !== 1'b1 || lvl_a !== exp_level() || lvl_b !== exp_level()) begin
      fails++; $display("FAIL cfg_pending_set: pend=%b/%b lvl=%0d/%0d want pend=1 lvl=%0d",
                        pend_a, pend_b, lvl_a, lvl_b, exp_level());
    end
    for (int l = 0; l < 4; l++) drive_line(1);
    drive_vsync(0, 0, 0, 0);
    tests++;
    if (pend_a !== 1'b0 || lvl_a !== 2'd0 || lvl_b !== 2'd0) begin
      fails++; $display("FAIL cfg_apply: pend=%b lvl=%0d/%0d want pend=0 lvl=0", pend_a, lvl_a, lvl_b);
    end
    for (int l = 1; l <= 6; l++) begin
      drive_line(1);
      tests++;
      if (lvl_a !== ((l % 2) ? 2'd2 : 2'd0) || lvl_b !== lvl_a) begin
        fails++; $display("FAIL cfg_pattern line%0d: got %0d/%0d want %0d", l, lvl_a, lvl_b, (l % 2) ? 2 : 0);
      end
    end
  endtask

  task automatic test_cfg_at_vsync();
    drive_vsync(1, 2'd3, 3'd0, 8'd1);
    tests++;
    if (pend_a !== 1'b0 || lvl_a !== 2'd3 || lvl_b !== 2'd3) begin
      fails++; $display("FAIL vs_cfg_apply: pend=%b lvl=%0d/%0d want pend=0 lvl=3", pend_a, lvl_a, lvl_b);
    end
    for (int l = 0; l < 8; l++) begin
      drive_line($urandom_range(0, 1));
      tests++;
      if (pend_a !== 1'b0 || pend_b !== 1'b0 || lvl_a !== 2'd3 || lvl_b !== 2'd3) begin
        fails++; $display("FAIL vs_cfg_line%0d: pend=%b/%b lvl=%0d/%0d want pend=0 lvl=3",
                          l, pend_a, pend_b, lvl_a, lvl_b);
      end
    end
  endtask

  task automatic test_blank_lines();
    int act_n = 0;
    cfg_write(2'($urandom_range(1, 3)), 3'd2, 8'b100);
    drive_vsync(0, 0, 0, 0);
    for (int l = 0; l < 24; l++) begin
      bit a = $urandom_range(0, 2) != 0;
      act_n += a;
      drive_line(a);
      tests++;
      if (lvl_a !== exp_level() || lvl_b !== exp_level()) begin
        fails++; $display("FAIL blank_level line%0d: got %0d/%0d want %0d", l, lvl_a, lvl_b, exp_level());
      end
    end
    drive_vsync(0, 0, 0, 0);
    tests++;
    if (fl_a !== 12'(act_n) || fl_b !== 8'(act_n)) begin
      fails++; $display("FAIL blank_count: got %0d/%0d want %0d", fl_a, fl_b, act_n);
    end
  endtask

  task automatic test_stable();
    int sizes[5] = '{240, 240, 241, 300, 300};
    for (int f = 0; f < 5; f++) begin
      for (int l = 0; l < sizes[f]; l++) drive_line(1);
      drive_vsync(0, 0, 0, 0);
      tests++;
      if (fl_a !== 12'(last_of(hist12)) || fl_b !== 8'(last_of(hist8)) ||
          stb_a !== stable_of(hist12) || stb_b !== stable_of(hist8)) begin
        fails++; $display("FAIL stable f%0d: fl=%0d/%0d stable=%b/%b want fl=%0d/%0d stable=%b/%b", f,
                          fl_a, fl_b, stb_a, stb_b, last_of(hist12), last_of(hist8), stable_of(hist12), stable_of(hist8));
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(5, 30);
      for (int l = 0; l < n; l++) begin
        if ($urandom_range(0, 9) == 0)
          cfg_write(2'($urandom), 3'($urandom), 8'($urandom));
        drive_line($urandom_range(0, 3) != 0);
        tests++;
        if (lvl_a !== exp_level() || lvl_b !== exp_level() || pend_a !== m_pend || pend_b !== m_pend) begin
          fails++; $display("FAIL rand_line f%0d l%0d: lvl=%0d/%0d pend=%b/%b want lvl=%0d pend=%b",
                            f, l, lvl_a, lvl_b, pend_a, pend_b, exp_level(), m_pend);
        end
      end
      if ($urandom_range(0, 2) == 0) drive_vsync(1, 2'($urandom), 3'($urandom), 8'($urandom));
      else drive_vsync(0, 0, 0, 0);
      tests++;
      if (fl_a !== 12'(last_of(hist12)) || stb_a !== stable_of(hist12) || pend_a !== 1'b0 ||
          lvl_a !== exp_level()) begin
        fails++; $display("FAIL rand_frame f%0d: fl=%0d stable=%b pend=%b lvl=%0d want fl=%0d stable=%b pend=0 lvl=%0d",
                          f, fl_a, stb_a, pend_a, lvl_a, last_of(hist12), stable_of(hist12), exp_level());
      end
    end
  endtask

  task automatic test_reset_midline();
    cfg_write(2'd1, 3'd0, 8'd1);
    for (int i = 0; i < 3; i++) begin de_in = 1'b1; tick(); end
    #2 reset_n = 1'b0; de_in = 1'b0;
    #1;
    tests++;
    if ({lvl_a, lvl_b, pend_a, pend_b, fl_a, fl_b, stb_a, stb_b} !== '0) begin
      fails++; $display("FAIL async_reset: lvl=%0d/%0d pend=%b/%b fl=%0d/%0d stable=%b/%b want all 0",
                        lvl_a, lvl_b, pend_a, pend_b, fl_a, fl_b, stb_a, stb_b);
    end
    model_reset();
    tick(); reset_n = 1'b1; tick();
    drive_line(0);
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 5; l++) drive_line(1);
      drive_vsync(0, 0, 0, 0);
      tests++;
      if (fl_a !== 12'd5 || fl_b !== 8'd5 || stb_a !== (f >= 1) || lvl_a !== 2'd0) begin
        fails++; $display("FAIL post_reset f%0d: fl=%0d/%0d stable=%b lvl=%0d want fl=5 stable=%0d lvl=0",
                          f, fl_a, fl_b, stb_a, lvl_a, f >= 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_cfg_midframe();
    test_cfg_at_vsync();
    test_blank_lines();
    test_stable();
    test_random();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
